// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store controller.
//   - MemControl size encodings (W, HU, H, BU, B); undefined codes act as W.
//   - FSM state encoding.
//   - size_mask / size_bytes helpers used for byte-enable generation and
//     word-crossing detection.
package lsu_pkg;

    localparam logic [2:0] SZ_W  = 3'b000;
    localparam logic [2:0] SZ_HU = 3'b001;
    localparam logic [2:0] SZ_H  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b011;
    localparam logic [2:0] SZ_B  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    // Byte-enable pattern of an access at offset 0.
    function automatic logic [3:0] size_mask(input logic [2:0] size);
        logic [3:0] mask;
        case (size)
            SZ_H, SZ_HU: mask = 4'b0011;
            SZ_B, SZ_BU: mask = 4'b0001;
            default:     mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // Number of bytes touched by an access.
    function automatic logic [2:0] size_bytes(input logic [2:0] size);
        logic [2:0] n;
        case (size)
            SZ_H, SZ_HU: n = 3'd2;
            SZ_B, SZ_BU: n = 3'd1;
            default:     n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: bundle of the request, response and memory-side signals of
// the load/store controller.
//   slave  : the controller (accepts requests, returns responses, drives memory)
//   master : its environment (core issuing requests plus the data memory,
//            which returns mem_rdata combinationally for mem_addr)
interface lsu_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_size;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_we, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_we, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load-data alignment.
//   data   in  64  {hi word, lo word} as read from memory
//   off    in  2   byte offset of the access within the lo word
//   size   in  3   MemControl size code
//   result out 32  data shifted down by off, truncated to size and
//                  sign-extended (H, B) or zero-extended (HU, BU, W)
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] data,
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = 32'(data >> {off, 3'b000});

    always_comb begin
        result = shifted;
        case (size)
            SZ_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            SZ_HU:   result = {16'b0, shifted[15:0]};
            SZ_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            SZ_BU:   result = {24'b0, shifted[7:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator between the core and a word-organised data
// memory with byte enables.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    lsu_ctrl_if.slave: req_* handshake in, resp_* handshake out,
//          mem_* word-aligned memory port (mem_rdata is combinational)
// Optional feature macro LSU_MISALIGNED_SPLIT_EN:
//   defined   - word-crossing accesses are split into two memory cycles
//   undefined - word-crossing accesses are rejected with resp_err=1 and no
//               memory cycle; misaligned but non-crossing accesses still work
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | req_ready=1, waiting for a request
// ACC0    | memory cycle on the word holding the first byte
// ACC1    | memory cycle on the following word (crossing access only)
// RESP    | resp_valid=1, holding the response until resp_ready
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BYTE_SIZE  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.slave  bus
);

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    lsu_state_t            state;
    logic                  we_q;
    logic [2:0]            size_q;
    logic [1:0]            off_q;
    logic                  cross_q;
    logic [ADDR_WIDTH-1:0] addr_hi_q;
    logic [3:0]            be_hi_q;
    logic [31:0]           wdata_hi_q;
    logic [31:0]           lo_q;
    logic                  err_q;

    logic [1:0]            req_off;
    logic [ADDR_WIDTH-1:0] req_word;
    logic [7:0]            be_wide;
    logic [63:0]           wdata_wide;
    logic                  req_cross;
    logic                  req_reject;

    logic [31:0]           align_hi;
    logic [31:0]           align_lo;
    logic [31:0]           load_result;

    assign req_off    = bus.req_addr[1:0];
    assign req_word   = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
    // Upper nibble of the shifted mask is the ACC1 enable (mask >> (4-off)).
    assign be_wide    = {4'b0, size_mask(bus.req_size)} << req_off;
    assign wdata_wide = {32'b0, bus.req_wdata} << {req_off, 3'b000};
    assign req_cross  = ({1'b0, req_off} + size_bytes(bus.req_size)) > 3'(BYTE_SIZE);
    assign req_reject = !SPLIT_EN && req_cross;

    // The response is built on the edge leaving the last memory cycle, so the
    // word being read in that cycle comes straight from mem_rdata.
    assign align_hi = (state == ST_ACC1) ? bus.mem_rdata : 32'b0;
    assign align_lo = (state == ST_ACC0) ? bus.mem_rdata : lo_q;

    lsu_load_align u_load_align (
        .data   ({align_hi, align_lo}),
        .off    (off_q),
        .size   (size_q),
        .result (load_result)
    );

    assign bus.resp_err = SPLIT_EN ? 1'b0 : err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_addr   <= '0;
            bus.mem_we     <= 1'b0;
            bus.mem_be     <= '0;
            bus.mem_wdata  <= '0;
            err_q          <= 1'b0;
            we_q           <= 1'b0;
            size_q         <= SZ_W;
            off_q          <= '0;
            cross_q        <= 1'b0;
            addr_hi_q      <= '0;
            be_hi_q        <= '0;
            wdata_hi_q     <= '0;
            lo_q           <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        we_q          <= bus.req_we;
                        size_q        <= bus.req_size;
                        off_q         <= req_off;
                        cross_q       <= req_cross;
                        addr_hi_q     <= req_word + ADDR_WIDTH'(BYTE_SIZE);
                        be_hi_q       <= be_wide[7:4];
                        wdata_hi_q    <= wdata_wide[63:32];
                        if (req_reject) begin
                            state          <= ST_RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_rdata <= '0;
                            err_q          <= 1'b1;
                        end else begin
                            state         <= ST_ACC0;
                            bus.mem_addr  <= req_word;
                            bus.mem_we    <= bus.req_we;
                            bus.mem_be    <= be_wide[3:0];
                            bus.mem_wdata <= wdata_wide[31:0];
                        end
                    end
                end
                ST_ACC0: begin
                    lo_q <= bus.mem_rdata;
                    if (cross_q) begin
                        state         <= ST_ACC1;
                        bus.mem_addr  <= addr_hi_q;
                        bus.mem_be    <= be_hi_q;
                        bus.mem_wdata <= wdata_hi_q;
                    end else begin
                        state          <= ST_RESP;
                        bus.mem_we     <= 1'b0;
                        bus.mem_be     <= '0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= we_q ? 32'b0 : load_result;
                    end
                end
                ST_ACC1: begin
                    state          <= ST_RESP;
                    bus.mem_we     <= 1'b0;
                    bus.mem_be     <= '0;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= we_q ? 32'b0 : load_result;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        state          <= ST_IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        err_q          <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
